alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised ALU with an iterative multiply/divide engine for the MIPS32 datapath. Accepts one operation per handshake and returns a registered result, flags, and a HI word. Logic, add/sub, shift and compare-branch ops complete in 1 cycle; multiply/divide take WIDTH+1 cycles. Sits in the execute stage and drives the HI/LO register writeback and the branch decision.

## Interface
- `WIDTH`, default 32: operand/result width; must be a power of two, at least 8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: engine can accept; a transfer happens when `in_valid & in_ready`.
- `op` in 5: opcode (`alu_pkg::alu_op_e`).
- `a`, `b` in WIDTH: operands.
- `out_valid` out 1: one-cycle pulse, result fields valid.
- `result` out WIDTH: ALU result, or LO (product low / quotient).
- `hi` out WIDTH: product high or remainder; 0 for other ops.
- `ov` out 1: signed overflow (ADD, SUB, signed DIV of MIN/-1); else 0.
- `branch_yes` out 1: compare outcome for ops 0x08–0x0D; else 0.
- `zero` out 1: `result == 0`.
- `div_by_zero` out 1: DIV/DIVU with `b == 0`.

## Operation
- Opcodes:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 NOR.
  - 0x06 SLL, 0x07 SRL: shift amount `b[$clog2(WIDTH)-1:0]`.
  - 0x08 BEQ, 0x09 BNE, 0x0A BGE, 0x0B BGT, 0x0C BLE, 0x0D BLT: signed compares; `result = a - b`.
  - 0x0E ADDU, 0x0F SUBU: `ov = 0`.
  - 0x10 MULT, 0x11 MULTU, 0x12 DIV, 0x13 DIVU.
  - 0x14–0x1F illegal: `result = 0`, all flags 0, still 1-cycle.
- ADD/SUB overflow: sign of both operands (b inverted for SUB) equal and differs from the sum sign.
- FSM states `IDLE`, `MUL`, `DIV`.
  - `IDLE`: `in_ready = 1`. A single-cycle op registers its outputs and pulses `out_valid` next cycle. MULT* goes to `MUL`, DIV* to `DIV`; both load `cnt = WIDTH`.
  - `MUL`: shift-add on unsigned magnitudes into a 2·WIDTH accumulator, one bit per cycle.
  - `DIV`: restoring division, one quotient bit per cycle.
  - In `MUL`/`DIV`, `cnt` decrements each cycle. At `cnt == 1` the sign fix is applied, outputs are registered, and state returns to `IDLE`.
- Sign rules:
  - MULT: product negated if `a[W-1] ^ b[W-1]`.
  - DIV: quotient sign `a ^ b`, remainder takes sign of `a`.
  - MULTU/DIVU: no sign handling.
- Division by zero: `result` all ones, `hi = a`, `div_by_zero = 1`; iterations still run the full WIDTH cycles.
- Signed DIV of MIN by -1: `result = MIN`, `hi = 0`, `ov = 1`.
- `in_valid` while `in_ready = 0` is ignored; the requester holds the request.
- There is no backpressure on the output; the consumer always takes the pulse.

## Timing
- Reset:
  - State `IDLE`, `cnt = 0`.
  - `in_ready = 1`.
  - `out_valid`, `result`, `hi`, `ov`, `branch_yes`, `div_by_zero` all 0.
  - `zero = 1`.
- Single-cycle ops: accepted at edge N, `out_valid` high in cycle N+1. Back-to-back acceptance every cycle.
- MUL/DIV: accepted at edge N, `in_ready` low cycles N+1..N+WIDTH, `out_valid` and `in_ready` high together in cycle N+WIDTH+1. A new op can be accepted in that same cycle.
- Outputs hold their last value after `out_valid` drops.
- Reset mid-iteration aborts the op with no `out_valid`.

## Configuration
- `ALU_MULDIV_EN` defined: MUL/DIV engine and `MUL`/`DIV` states are built.
- Undefined: opcodes 0x10–0x13 decode as illegal (1-cycle, `result = 0`, `hi = 0`). `in_ready` is tied to 1 and the `div_by_zero` output is tied to 0.

## Structure
- `alu_pkg` holds:
  - `alu_op_e` opcode enum.
  - `alu_state_e` FSM enum.
  - `ALU_OP_W = 5`.
- Sub-module `alu_muldiv_core`:
  - Contents: iterative datapath, counter, sign fix.
  - Interface: `start` / `done` / `busy`.
  - Compiled only under `ALU_MULDIV_EN`.
- The top level holds the single-cycle ALU, the output registers and the handshake.

## Test plan
- ADD `a = 0x7FFFFFFF`, `b = 1` → `result = 0x80000000`, `ov = 1`, `out_valid` 1 cycle after accept. ADDU with the same operands → `ov = 0`.
- BLT `a = 0xFFFFFFFF`, `b = 1` → `branch_yes = 1` (signed compare). BEQ `5, 5` → `branch_yes = 1`, `zero = 1`.
- MULT `a = -3`, `b = 7` → `hi = 0xFFFFFFFF`, `result = 0xFFFFFFEB`. `out_valid` 33 cycles after accept; `in_ready` low for 32 cycles.
- DIV `-7 / 2` → `result = -3`, `hi = -1`. DIVU `x / 0` → `result = 0xFFFFFFFF`, `hi = x`, `div_by_zero = 1`. DIV `0x80000000 / -1` → `ov = 1`.
- Back-to-back: XOR on 3 consecutive cycles → 3 consecutive `out_valid` pulses. A MULT followed by an ADD held on `in_valid` → ADD accepted in the MULT `out_valid` cycle.
- Assert `rst` at iteration 10 of DIVU → no `out_valid`, all outputs at reset values, `in_ready = 1`. Without `ALU_MULDIV_EN`, MULT → `result = 0`, `hi = 0`, 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the alu_iter execute-stage ALU.
package alu_pkg;

    localparam int ALU_OP_W = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD   = 5'h00,
        OP_SUB   = 5'h01,
        OP_AND   = 5'h02,
        OP_OR    = 5'h03,
        OP_XOR   = 5'h04,
        OP_NOR   = 5'h05,
        OP_SLL   = 5'h06,
        OP_SRL   = 5'h07,
        OP_BEQ   = 5'h08,
        OP_BNE   = 5'h09,
        OP_BGE   = 5'h0A,
        OP_BGT   = 5'h0B,
        OP_BLE   = 5'h0C,
        OP_BLT   = 5'h0D,
        OP_ADDU  = 5'h0E,
        OP_SUBU  = 5'h0F,
        OP_MULT  = 5'h10,
        OP_MULTU = 5'h11,
        OP_DIV   = 5'h12,
        OP_DIVU  = 5'h13
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_iter_if.sv
// Request/response bundle between the execute-stage requester and alu_iter.
interface alu_iter_if #(
    parameter int WIDTH = 32
);
    logic                          in_valid;
    logic                          in_ready;
    logic [alu_pkg::ALU_OP_W-1:0]  op;
    logic [WIDTH-1:0]              a;
    logic [WIDTH-1:0]              b;
    logic                          out_valid;
    logic [WIDTH-1:0]              result;
    logic [WIDTH-1:0]              hi;
    logic                          ov;
    logic                          branch_yes;
    logic                          zero;
    logic                          div_by_zero;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, result, hi, ov, branch_yes, zero, div_by_zero
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, result, hi, ov, branch_yes, zero, div_by_zero
    );
endinterface

// File: rtl/alu_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Only built when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module alu_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             ov,
    output logic             dbz
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt, prod;
    logic [WIDTH-1:0]   mb, a_raw, mag_a, mag_b;
    logic [WIDTH:0]     add_s;
    logic [WIDTH+1:0]   trial;
    logic               div_r, neg_q, neg_r, ov_r, dbz_r;

    assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

    // acc = {upper half, lower half}: product/multiplier for MUL, remainder/quotient for DIV
    assign add_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
    assign trial = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, mb};
    assign acc_nxt = !div_r ? {add_s, acc[WIDTH-1:1]} :
                     trial[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0} :
                                      {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign prod = neg_q ? -acc_nxt : acc_nxt;

    always_comb begin
        lo = prod[WIDTH-1:0];
        hi = prod[2*WIDTH-1:WIDTH];
        if (div_r) begin
            lo = neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
            hi = neg_r ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
            if (dbz_r) begin
                lo = '1;
                hi = a_raw;
            end
        end
    end

    assign busy = (cnt != '0);
    assign done = (cnt == CNT_W'(1));
    assign ov   = ov_r;
    assign dbz  = dbz_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            acc   <= '0;
            mb    <= '0;
            a_raw <= '0;
            div_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ov_r  <= 1'b0;
            dbz_r <= 1'b0;
        end else if (start) begin
            cnt   <= CNT_W'(WIDTH);
            acc   <= {{WIDTH{1'b0}}, mag_a};
            mb    <= mag_b;
            a_raw <= a;
            div_r <= is_div;
            neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= is_signed && a[WIDTH-1];
            ov_r  <= is_signed && is_div && (a == MIN_V) && (b == '1);
            dbz_r <= is_div && (b == '0);
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            acc <= acc_nxt;
        end
    end
endmodule
`endif

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle logic/arith/shift/compare plus optional
// iterative MUL/DIV engine (enabled by ALU_MULDIV_EN).
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    alu_iter_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0] sum_c, dif_c, res_c, result_r, hi_r;
    logic             ov_c, br_c, out_valid_r, ov_r, br_r, zero_r;
    logic             accept, is_md;

    assign sum_c = bus.a + bus.b;
    assign dif_c = bus.a - bus.b;

    always_comb begin
        res_c = '0;
        ov_c  = 1'b0;
        br_c  = 1'b0;
        case (bus.op)
            OP_ADD:  begin
                res_c = sum_c;
                ov_c  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB:  begin
                res_c = dif_c;
                ov_c  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif_c[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  res_c = bus.a & bus.b;
            OP_OR:   res_c = bus.a | bus.b;
            OP_XOR:  res_c = bus.a ^ bus.b;
            OP_NOR:  res_c = ~(bus.a | bus.b);
            OP_SLL:  res_c = bus.a << bus.b[SH_W-1:0];
            OP_SRL:  res_c = bus.a >> bus.b[SH_W-1:0];
            OP_BEQ:  begin res_c = dif_c; br_c = (bus.a == bus.b); end
            OP_BNE:  begin res_c = dif_c; br_c = (bus.a != bus.b); end
            OP_BGE:  begin res_c = dif_c; br_c = ($signed(bus.a) >= $signed(bus.b)); end
            OP_BGT:  begin res_c = dif_c; br_c = ($signed(bus.a) >  $signed(bus.b)); end
            OP_BLE:  begin res_c = dif_c; br_c = ($signed(bus.a) <= $signed(bus.b)); end
            OP_BLT:  begin res_c = dif_c; br_c = ($signed(bus.a) <  $signed(bus.b)); end
            OP_ADDU: res_c = sum_c;
            OP_SUBU: res_c = dif_c;
            default: ;
        endcase
    end

`ifdef ALU_MULDIV_EN
    alu_state_e       state;
    logic             md_start, md_done, md_busy, md_ov, md_dbz, is_div, is_signed, dbz_r;
    logic [WIDTH-1:0] md_lo, md_hi;

    assign is_md     = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                       (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign md_start  = accept && is_md;

    alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .is_div    (is_div),
        .is_signed (is_signed),
        .a         (bus.a),
        .b         (bus.b),
        .busy      (md_busy),
        .done      (md_done),
        .lo        (md_lo),
        .hi        (md_hi),
        .ov        (md_ov),
        .dbz       (md_dbz)
    );

    // the core counter is a register, so in_ready is registered as well
    assign bus.in_ready    = !md_busy;
    assign bus.div_by_zero = dbz_r;
`else
    assign is_md           = 1'b0;
    assign bus.in_ready    = 1'b1;
    assign bus.div_by_zero = 1'b0;
`endif

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= '0;
            hi_r        <= '0;
            ov_r        <= 1'b0;
            br_r        <= 1'b0;
            zero_r      <= 1'b1;
`ifdef ALU_MULDIV_EN
            dbz_r       <= 1'b0;
            state       <= IDLE;
`endif
        end else begin
            out_valid_r <= 1'b0;
            if (accept && !is_md) begin
                out_valid_r <= 1'b1;
                result_r    <= res_c;
                hi_r        <= '0;
                ov_r        <= ov_c;
                br_r        <= br_c;
                zero_r      <= (res_c == '0);
`ifdef ALU_MULDIV_EN
                dbz_r       <= 1'b0;
`endif
            end
`ifdef ALU_MULDIV_EN
            case (state)
                IDLE: if (md_start) state <= is_div ? DIV : MUL;
                MUL, DIV: begin
                    if (md_done) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b1;
                        result_r    <= md_lo;
                        hi_r        <= md_hi;
                        ov_r        <= md_ov;
                        br_r        <= 1'b0;
                        zero_r      <= (md_lo == '0);
                        dbz_r       <= md_dbz;
                    end
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.result     = result_r;
    assign bus.hi         = hi_r;
    assign bus.ov         = ov_r;
    assign bus.branch_yes = br_r;
    assign bus.zero       = zero_r;
endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: driver pushes hand-computed expectations,
// a negedge monitor pops and compares on every out_valid pulse.
module tb_alu_iter;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        string       name;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic        ov;
        logic        br;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   no_expect = 1'b0;
    exp_t sb[$];

    alu_iter_if #(.WIDTH(W)) bus();

    alu_iter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // {out_valid,result,hi,ov,branch_yes,zero,div_by_zero,in_ready}
    task automatic check_reset(input string name);
        check(name,
              {bus.out_valid, bus.result, bus.hi, bus.ov, bus.branch_yes, bus.zero, bus.div_by_zero, bus.in_ready},
              {1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    endtask

    task automatic issue(input string name, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic [W-1:0] eh,
                         input logic eov, input logic ebr, input logic edbz, output int waits);
        int   lat = 0;
        exp_t e;
`ifdef ALU_MULDIV_EN
        if (op >= 5'h10 && op <= 5'h13) lat = W;
`endif
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        waits = 0;
        while (!bus.in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.accept: in_ready never rose", name);
        end else if (!no_expect) begin
            e.name = name; e.res = er; e.hi = eh; e.ov = eov; e.br = ebr; e.dbz = edbz;
            e.cyc = cyc + 1 + lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got pulse at cycle %0d want none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name,
                      {bus.result, bus.hi, bus.ov, bus.branch_yes, bus.zero, bus.div_by_zero},
                      {e.res, e.hi, e.ov, e.br, (e.res == '0), e.dbz});
                check({e.name, ".lat"}, cyc, e.cyc);
            end
        end
    end

    initial begin
        int w;
        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        // single-cycle ops, issued back to back
        issue("add_ov",  OP_ADD,  32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 0, 0, w);
        issue("addu",    OP_ADDU, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 0, w);
        issue("sub_ov",  OP_SUB,  32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 1, 0, 0, w);
        issue("subu",    OP_SUBU, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 0, 0, 0, w);
        issue("and",     OP_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 0, 0, w);
        issue("or",      OP_OR,   32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0, 0, 0, 0, w);
        issue("nor",     OP_NOR,  32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0, w);
        issue("sll_amt", OP_SLL,  32'h1, 32'd33, 32'h2, 0, 0, 0, 0, w);
        issue("srl",     OP_SRL,  32'h80000000, 32'd31, 32'h1, 0, 0, 0, 0, w);
        issue("blt",     OP_BLT,  32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 0, 0, 1, 0, w);
        issue("beq",     OP_BEQ,  32'd5, 32'd5, 32'h0, 0, 0, 1, 0, w);
        issue("bne",     OP_BNE,  32'd5, 32'd6, 32'hFFFFFFFF, 0, 0, 1, 0, w);
        issue("bge",     OP_BGE,  32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 0, 0, 0, 0, w);
        issue("bgt",     OP_BGT,  32'd2, 32'd1, 32'h1, 0, 0, 1, 0, w);
        issue("ble",     OP_BLE,  32'd1, 32'd1, 32'h0, 0, 0, 1, 0, w);
        issue("illegal", 5'h15,   32'd3, 32'd4, 32'h0, 0, 0, 0, 0, w);
        issue("xor0",    OP_XOR,  32'h0000000F, 32'h000000F0, 32'h000000FF, 0, 0, 0, 0, w);
        issue("xor1",    OP_XOR,  32'hAAAA5555, 32'hFFFFFFFF, 32'h5555AAAA, 0, 0, 0, 0, w);
        issue("xor2",    OP_XOR,  32'h12345678, 32'h12345678, 32'h0, 0, 0, 0, 0, w);
        idle();

        // outputs hold after the pulse
        issue("hold_and", OP_AND, 32'hFFFF0000, 32'h0FF00000, 32'h0FF00000, 0, 0, 0, 0, w);
        idle();
        repeat (3) @(negedge clk);
        check("hold", {bus.out_valid, bus.result}, {1'b0, 32'h0FF00000});

`ifdef ALU_MULDIV_EN
        issue("mult_neg", OP_MULT,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 0, 0, 0, w);
        issue("add_held", OP_ADD,   32'd10, 32'd20, 32'd30, 0, 0, 0, 0, w);
        check("mult_inready_low", w, W);
        issue("multu",    OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h1, 0, 0, 0, w);
        issue("mult_min", OP_MULT,  32'h80000000, 32'd2, 32'h0, 32'hFFFFFFFF, 0, 0, 0, w);
        issue("div_neg",  OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0, w);
        issue("divu",     OP_DIVU,  32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, w);
        issue("divu_big", OP_DIVU,  32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32'd1, 0, 0, 0, w);
        issue("divu_z",   OP_DIVU,  32'h00001234, 32'd0, 32'hFFFFFFFF, 32'h00001234, 0, 0, 1, w);
        issue("div_z",    OP_DIV,   32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 0, 0, 1, w);
        issue("div_min",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1, 0, 0, w);
        issue("sll_after", OP_SLL,  32'h3, 32'd4, 32'h30, 0, 0, 0, 0, w);
        idle();
        repeat (3) @(negedge clk);

        // reset in the middle of a DIVU: no pulse, all outputs back to reset values
        no_expect = 1'b1;
        issue("divu_abort", OP_DIVU, 32'd1000, 32'd3, 0, 0, 0, 0, 0, w);
        idle();
        no_expect = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy", bus.in_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset("abort_reset");
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        check_reset("abort_after");
`else
        issue("mult_off", OP_MULT,  32'hFFFFFFFD, 32'd7, 32'h0, 32'h0, 0, 0, 0, w);
        issue("divu_off", OP_DIVU,  32'd5, 32'd0, 32'h0, 32'h0, 0, 0, 0, w);
        issue("add_next", OP_ADD,   32'd1, 32'd1, 32'd2, 0, 0, 0, 0, w);
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("after_reset");
`endif

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
